// File: rtl/and_gate_if.sv
// Bus bundle for the and_gate block. It carries the operands, the counter
// clear and every result. The master drives the operands and clear, and the
// slave (the gate) drives the results.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_reg;
  logic             y_all;
  logic             rise;
  logic [CNT_W-1:0] high_cnt;

  modport master (
    output a, b, clr,
    input  y, y_reg, y_all, rise, high_cnt
  );

  modport slave (
    input  a, b, clr,
    output y, y_reg, y_all, rise, high_cnt
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND gate with some registered observers:
//   y        - combinational a & b. It stays live even while in reset.
//   y_reg    - y delayed by one clock.
//   y_all    - registered reduction-AND of a & b, which is "every bit set".
//   rise     - one-cycle pulse on the cycle y_all first reads 1.
//   high_cnt - saturating count of edges seen while y_all was 1.
// The rst input is asynchronous and active-high. The clr input clears only
// the counter, on a clock edge.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  and_gate_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] y_next;
  logic             all_next;

  // Pure combinational AND. It has no dependence on clk, rst or clr.
  always_comb begin
    y_next   = bus.a & bus.b;
    all_next = &y_next;
  end

  assign bus.y = y_next;

  // Result pipeline. The rise pulse compares the incoming all-ones value
  // with the value currently held, so it lines up with y_all's first 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y_reg <= '0;
      bus.y_all <= 1'b0;
      bus.rise  <= 1'b0;
    end else begin
      bus.y_reg <= y_next;
      bus.y_all <= all_next;
      bus.rise  <= all_next & ~bus.y_all;
    end
  end

  // Counter of high cycles. It uses the registered y_all, so it lags y_all
  // by one edge. It sticks at all-ones, and clr takes precedence over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.high_cnt <= '0;
    end else if (bus.clr) begin
      bus.high_cnt <= '0;
    end else if (bus.y_all && (bus.high_cnt != CNT_MAX)) begin
      bus.high_cnt <= bus.high_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate. It uses three instances:
//   t_* : WIDTH=1 truth table. Its clock is held still.
//   m_* : WIDTH=4, CNT_W=16. Covers latency, rise, clear, async reset.
//   s_* : WIDTH=4, CNT_W=3. Covers counter saturation.
module tb_and_gate;

  logic clk = 1'b0;
  logic rst;
  logic t_clk;
  logic t_rst;

  int check_count = 0;
  int fail_count  = 0;

  and_gate_if #(.WIDTH(1), .CNT_W(16)) t_if ();
  and_gate_if #(.WIDTH(4), .CNT_W(16)) m_if ();
  and_gate_if #(.WIDTH(4), .CNT_W(3))  s_if ();

  and_gate #(.WIDTH(1), .CNT_W(16)) u_tt  (.clk(t_clk), .rst(t_rst), .bus(t_if.slave));
  and_gate #(.WIDTH(4), .CNT_W(16)) u_main(.clk(clk),   .rst(rst),   .bus(m_if.slave));
  and_gate #(.WIDTH(4), .CNT_W(3))  u_sat (.clk(clk),   .rst(rst),   .bus(s_if.slave));

  // Free-running main clock with a period of 10 time units.
  always #5 clk = ~clk;

  // One comparison: counts it, and counts and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the operands and clear of the main instance.
  task automatic applyStimulus(input logic [3:0] a_v, input logic [3:0] b_v,
                               input logic clr_v);
    m_if.a   = a_v;
    m_if.b   = b_v;
    m_if.clr = clr_v;
  endtask

  // Advances past the next rising edge, leaving room before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    logic       prev_all;
    logic       exp_all;
    logic       exp_rise;
    logic [3:0] a_v;
    int         rise_seen;
    logic [1:0] ta [4];
    logic       ty [4];

    rst      = 1'b1;
    t_clk    = 1'b0;
    t_rst    = 1'b0;
    t_if.clr = 1'b0;
    s_if.a   = 4'h0;
    s_if.b   = 4'h0;
    s_if.clr = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0);

    // Truth table on the unclocked WIDTH=1 instance.
    ta = '{2'b00, 2'b01, 2'b10, 2'b11};
    ty = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      t_if.a = ta[i][1];
      t_if.b = ta[i][0];
      #1;
      checkOutput($sformatf("truth_%0d", i), 32'(t_if.y), 32'(ty[i]));
      #9;
    end

    // Reset state, and y staying live while in reset.
    checkOutput("rst_y_reg", 32'(m_if.y_reg), 32'h0);
    checkOutput("rst_y_all", 32'(m_if.y_all), 32'h0);
    checkOutput("rst_rise",  32'(m_if.rise),  32'h0);
    checkOutput("rst_cnt",   32'(m_if.high_cnt), 32'h0);
    applyStimulus(4'hF, 4'hA, 1'b0);
    #1;
    checkOutput("rst_y_live", 32'(m_if.y), 32'hA);

    // Latency check: y_reg follows one edge later, and y_all stays low.
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("lat_y_reg", 32'(m_if.y_reg), 32'hA);
    checkOutput("lat_y_all", 32'(m_if.y_all), 32'h0);
    checkOutput("lat_rise0", 32'(m_if.rise),  32'h0);

    // All ones: y_all and rise set together, and the count lags by one edge.
    applyStimulus(4'hF, 4'hF, 1'b0);
    #1;
    checkOutput("ones_y", 32'(m_if.y), 32'hF);
    tick();
    checkOutput("ones_y_all", 32'(m_if.y_all), 32'h1);
    checkOutput("ones_rise",  32'(m_if.rise),  32'h1);
    checkOutput("ones_cnt0",  32'(m_if.high_cnt), 32'h0);
    tick();
    checkOutput("ones_rise_drop", 32'(m_if.rise), 32'h0);
    checkOutput("ones_cnt1", 32'(m_if.high_cnt), 32'h1);
    tick();
    tick();
    checkOutput("ones_cnt3", 32'(m_if.high_cnt), 32'h3);

    // Async reset between edges. Registers clear at once, and y stays live.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_cnt",   32'(m_if.high_cnt), 32'h0);
    checkOutput("arst_y_reg", 32'(m_if.y_reg), 32'h0);
    checkOutput("arst_y_all", 32'(m_if.y_all), 32'h0);
    checkOutput("arst_rise",  32'(m_if.rise),  32'h0);
    checkOutput("arst_y",     32'(m_if.y),     32'hF);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("post_rst_rise", 32'(m_if.rise), 32'h1);
    checkOutput("post_rst_cnt",  32'(m_if.high_cnt), 32'h0);

    // Clear wins over a simultaneous increment and touches only the counter.
    for (int i = 0; i < 5; i++) tick();
    checkOutput("clr_pre_cnt5", 32'(m_if.high_cnt), 32'h5);
    applyStimulus(4'hF, 4'hF, 1'b1);
    tick();
    checkOutput("clr_cnt0",  32'(m_if.high_cnt), 32'h0);
    checkOutput("clr_y_all", 32'(m_if.y_all), 32'h1);
    checkOutput("clr_y_reg", 32'(m_if.y_reg), 32'hF);
    applyStimulus(4'hF, 4'hF, 1'b0);
    tick();
    checkOutput("clr_cnt1", 32'(m_if.high_cnt), 32'h1);

    // Rise pulses. Operand a alternates every two cycles, with b all ones.
    prev_all  = 1'b1;
    rise_seen = 0;
    for (int i = 0; i < 12; i++) begin
      a_v = ((i / 2) % 2 == 1) ? 4'hF : 4'h0;
      applyStimulus(a_v, 4'hF, 1'b0);
      tick();
      exp_all  = (a_v == 4'hF);
      exp_rise = exp_all & ~prev_all;
      checkOutput($sformatf("pulse_all_%0d", i),  32'(m_if.y_all), 32'(exp_all));
      checkOutput($sformatf("pulse_rise_%0d", i), 32'(m_if.rise),  32'(exp_rise));
      if (m_if.rise === 1'b1) rise_seen++;
      prev_all = exp_all;
    end
    checkOutput("pulse_total", 32'(rise_seen), 32'd3);

    // Saturation of the 3-bit counter. It reads 0..7 and then holds at 7.
    s_if.a = 4'hF;
    s_if.b = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("sat_all_%0d", k), 32'(s_if.y_all), 32'h1);
      checkOutput($sformatf("sat_cnt_%0d", k), 32'(s_if.high_cnt),
                  (k - 1 > 7) ? 32'd7 : 32'(k - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             check_count, fail_count);
    $finish;
  end

endmodule
